regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the integer and floating-point pipelines. It supports:
- configurable width, depth and read-port count (three read ports for fused multiply-add operands);
- two write ports: single-cycle writeback and long-latency/FPU writeback;
- same-cycle write-to-read bypass;
- a per-entry busy scoreboard;
- a post-reset clear sequencer that zeroes the array.

One instance sits in decode as the integer file (ZERO_REG=1), a second as the FP file (ZERO_REG=0).

## Interface
Parameters:
- DATA_W, 32, entry width in bits
- DEPTH, 32, number of entries; need not be a power of two
- NUM_RD, 3, number of read ports
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero
- ADDR_W, $clog2(DEPTH), derived; not overridden

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk_i  in  1  clock
  - rst_ni  in  1  asynchronous active-low reset
- Read ports:
  - rd_addr_i  in  NUM_RD x ADDR_W  read addresses
  - rd_data_o  out  NUM_RD x DATA_W  read data, combinational
- Write port A (single-cycle writeback):
  - wa_en_i  in  1  write enable
  - wa_addr_i  in  ADDR_W  write address
  - wa_data_i  in  DATA_W  write data
- Write port B (long-latency writeback):
  - wb_en_i  in  1  write enable
  - wb_addr_i  in  ADDR_W  write address
  - wb_data_i  in  DATA_W  write data
- Scoreboard and status:
  - busy_set_i  in  1  mark the destination busy at issue
  - busy_addr_i  in  ADDR_W  entry to mark
  - busy_o  out  DEPTH  registered busy bit per entry
  - ready_o  out  1  high once the clear sequence has finished

## Operation
- **FSM, two states, RF_CLEAR → RF_READY.**
  - Reset forces RF_CLEAR, clear counter 0, busy_o all 0, ready_o 0.
  - In RF_CLEAR, each edge writes 0 to entry[cnt] and increments cnt.
  - At cnt == DEPTH-1 the FSM writes that entry and moves to RF_READY. It remains there until the next reset.
- **During RF_CLEAR:**
  - all write enables and busy_set_i are ignored;
  - every rd_data_o reads 0.
- **Reset mid-operation** (rst_ni low in either state): asynchronous return to RF_CLEAR; the clear restarts from entry 0.
- **Reads (RF_READY):** rd_data_o[k] resolves in this priority order:
  1. 0 if ZERO_REG and the address is 0, or if the address is ≥ DEPTH;
  2. else wa_data_i if wa_en_i and wa_addr_i matches;
  3. else wb_data_i if wb_en_i and wb_addr_i matches;
  4. else the array entry.
- **Writes:**
  - Both ports write on the same edge.
  - If both target the same address, port A wins.
  - Writes to address ≥ DEPTH are dropped.
  - Writes to entry 0 are dropped when ZERO_REG=1.
- **Scoreboard:**
  - busy_set_i sets busy[busy_addr_i].
  - A port-B write clears busy[wb_addr_i].
  - Port-A writes never touch busy.
  - A set and a clear on the same entry in the same cycle: set wins.
  - With ZERO_REG=1, busy[0] is constantly 0. Out-of-range busy_addr_i is ignored.
- **Width:** addresses compare as unsigned ADDR_W values; data passes through unmodified.

## Timing
- **Read latency:** 0 cycles, combinational from rd_addr_i and the write ports. A write is visible through the bypass in the same cycle and from the array after the edge.
- **Write latency:** 1 edge.
- **busy_o:** registered; it updates 1 edge after busy_set_i or a port-B write.
- **ready_o:** registered. It rises on the DEPTH-th rising edge after rst_ni deasserts, e.g. edge 32 for DEPTH=32.
- **Reset values:** ready_o=0, busy_o=0, rd_data_o=0, FSM=RF_CLEAR. Array contents are undefined until cleared.
- **No backpressure:** the issue stage must hold while ready_o=0.

## Structure
- **Package regfile_pkg:**
  - rf_state_e enum {RF_CLEAR, RF_READY};
  - localparams for the default DATA_W and DEPTH, shared by the integer and FP instances.
- **Sub-module rf_read_port:** instantiated NUM_RD times via generate. It contains the zero, range and bypass muxing for one port.
- **Top level:** holds the array, the clear FSM and counter, the write logic and the scoreboard.

## Test plan
- **Reset clear:** rst_ni low then high, DEPTH=32.
  - ready_o=0 for edges 1..31 and 1 at edge 32.
  - All 32 entries read 0.
  - A wa write of 0xDEAD at edge 5 to addr 3 leaves entry 3 at 0.
- **Bypass and port conflict:** addr 7 written with wa_data_i=0x11111111 and wb_data_i=0x22222222 in the same cycle.
  - rd_data_o on addr 7 shows 0x11111111 in that cycle.
  - The entry holds 0x11111111 afterwards.
- **Zero register, ZERO_REG=1:**
  - Write 0xFFFFFFFF to addr 0, then read addr 0 → 0.
  - busy_set_i on addr 0 → busy_o[0] stays 0.
- **Zero register, ZERO_REG=0:** the same write reads back 0xFFFFFFFF.
- **Scoreboard:**
  - busy_set_i on addr 5 → busy_o[5]=1 next edge.
  - A port-B write to 5 → busy_o[5]=0 next edge.
  - busy_set_i and a port-B write to 9 in the same cycle → busy_o[9]=1.
- **Mid-operation reset:**
  - Write 0xABCD to addr 4, pulse rst_ni low → ready_o drops immediately.
  - After re-clear, addr 4 reads 0 and busy_o is all 0.
- **Non-power-of-two, DEPTH=24:**
  - Write 0x5 to addr 30 → dropped.
  - Read addr 30 → 0.
  - ready_o rises at edge 24.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register files.
// Used by the integer (ZERO_REG=1) and FP (ZERO_REG=0) instances.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_e;

  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;

endpackage

// File: rtl/regfile_mp_read_port.sv
// One combinational read port: zero/range masking, then A/B bypass.
// Ports: ready, addr, write ports A/B, arr_data (array entry) -> data.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter bit ZERO_REG = 1'b1,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] arr_data,
  output logic [DATA_W-1:0] data
);

  logic blank;

  always_comb begin
    blank = !ready
          || (int'(addr) >= DEPTH)
          || (ZERO_REG && addr == '0);
    data = arr_data;
    if (blank) begin
      data = '0;
    end else if (wa_en && wa_addr == addr) begin
      data = wa_data;
    end else if (wb_en && wb_addr == addr) begin
      data = wb_data;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: array, clear FSM, two write ports, busy scoreboard.
// Ports: clk_i/rst_ni, rd_addr_i/rd_data_o, wa_*, wb_*, busy_*, ready_o.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr_i,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data_o,
  input  logic                           wa_en_i,
  input  logic [ADDR_W-1:0]              wa_addr_i,
  input  logic [DATA_W-1:0]              wa_data_i,
  input  logic                           wb_en_i,
  input  logic [ADDR_W-1:0]              wb_addr_i,
  input  logic [DATA_W-1:0]              wb_data_i,
  input  logic                           busy_set_i,
  input  logic [ADDR_W-1:0]              busy_addr_i,
  output logic [DEPTH-1:0]               busy_o,
  output logic                           ready_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ready;
  logic              wa_ok, wb_ok, set_ok;

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) && !(ZERO_REG && a == '0);
  endfunction

  assign ready   = (state_q == RF_READY);
  assign ready_o = ready;
  assign busy_o  = busy_q;

  assign wa_ok  = ready && wa_en_i && writable(wa_addr_i);
  assign wb_ok  = ready && wb_en_i && writable(wb_addr_i);
  assign set_ok = ready && busy_set_i && writable(busy_addr_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RF_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST) begin
          state_d = RF_READY;
          cnt_d   = '0;
        end
      end
      RF_READY: ;
      default: state_d = RF_CLEAR;
    endcase
  end

  // Array has no reset; the clear walk zeroes it before reads are enabled.
  // Port A is applied last so it wins a same-address conflict.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!ready) begin
        if (int'(cnt_q) == i) mem[i] <= '0;
      end else begin
        if (wb_ok && int'(wb_addr_i) == i) mem[i] <= wb_data_i;
        if (wa_ok && int'(wa_addr_i) == i) mem[i] <= wa_data_i;
      end
    end
  end

  // Clear before set so an issue in the writeback cycle stays busy.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_ok && int'(wb_addr_i) == i) busy_d[i] = 1'b0;
      if (set_ok && int'(busy_addr_i) == i) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [DATA_W-1:0] arr;

    assign arr = (int'(rd_addr_i[k]) < DEPTH)
               ? mem[rd_addr_i[k]] : '0;

    rf_read_port #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .ZERO_REG(ZERO_REG),
      .ADDR_W  (ADDR_W)
    ) u_rd (
      .ready   (ready),
      .addr    (rd_addr_i[k]),
      .wa_en   (wa_en_i),
      .wa_addr (wa_addr_i),
      .wa_data (wa_data_i),
      .wb_en   (wb_en_i),
      .wb_addr (wb_addr_i),
      .wb_data (wb_data_i),
      .arr_data(arr),
      .data    (rd_data_o[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp: three configurations share stimulus
// (32/zero-reg, 32/no-zero-reg, 24/zero-reg) against a behavioural model.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0][4:0] rd_addr;
  logic wa_en, wb_en, bs_en;
  logic [4:0] wa_addr, wb_addr, bs_addr;
  logic [31:0] wa_data, wb_data;
  logic [2:0][31:0] rd0, rd1, rd2;
  logic [31:0] busy0, busy1;
  logic [23:0] busy2;
  logic ready0, ready1, ready2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DEPTH(32), .ZERO_REG(1'b1)) u0 (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_addr_i(rd_addr), .rd_data_o(rd0),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .busy_set_i(bs_en), .busy_addr_i(bs_addr),
    .busy_o(busy0), .ready_o(ready0)
  );

  regfile_mp #(.DEPTH(32), .ZERO_REG(1'b0)) u1 (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_addr_i(rd_addr), .rd_data_o(rd1),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .busy_set_i(bs_en), .busy_addr_i(bs_addr),
    .busy_o(busy1), .ready_o(ready1)
  );

  regfile_mp #(.DEPTH(24), .ZERO_REG(1'b1)) u2 (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_addr_i(rd_addr), .rd_data_o(rd2),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .busy_set_i(bs_en), .busy_addr_i(bs_addr),
    .busy_o(busy2), .ready_o(ready2)
  );

  // Behavioural model: per config, contents, busy bits, edges since reset.
  logic [31:0] mm [3][32];
  logic [31:0] mb [3];
  int edges [3];

  function automatic int dep(int d);
    return (d == 2) ? 24 : 32;
  endfunction

  function automatic bit zr(int d);
    return d != 1;
  endfunction

  function automatic bit ok(int d, logic [4:0] a);
    return (int'(a) < dep(d)) && !(zr(d) && a == 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(int d, logic [4:0] a);
    if (edges[d] < dep(d)) return 32'h0;
    if (int'(a) >= dep(d) || (zr(d) && a == 5'd0)) return 32'h0;
    if (wa_en && wa_addr == a) return wa_data;
    if (wb_en && wb_addr == a) return wb_data;
    return mm[d][a];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      edges[d] = 0;
      mb[d] = 32'h0;
      for (int a = 0; a < 32; a++) mm[d][a] = 32'h0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (edges[d] < dep(d)) begin
          edges[d]++;
        end else begin
          if (wb_en && ok(d, wb_addr)) begin
            mm[d][wb_addr] = wb_data;
            mb[d][wb_addr] = 1'b0;
          end
          if (wa_en && ok(d, wa_addr)) mm[d][wa_addr] = wa_data;
          if (bs_en && ok(d, bs_addr)) mb[d][bs_addr] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; bs_en = 1'b0;
    wa_addr = 5'd0; wb_addr = 5'd0; bs_addr = 5'd0;
    wa_data = 32'h0; wb_data = 32'h0;
  endtask

  task automatic rand_rd();
    for (int k = 0; k < 3; k++) rd_addr[k] = 5'($urandom);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rd0_p%0d", k), rd0[k], exp_rd(0, rd_addr[k]));
      chk($sformatf("rd1_p%0d", k), rd1[k], exp_rd(1, rd_addr[k]));
      chk($sformatf("rd2_p%0d", k), rd2[k], exp_rd(2, rd_addr[k]));
    end
    chk("busy0", busy0, mb[0]);
    chk("busy1", busy1, mb[1]);
    chk("busy2", {8'h0, busy2}, mb[2] & 32'h00FF_FFFF);
    chk("ready0", {31'h0, ready0}, 32'(edges[0] >= 32));
    chk("ready1", {31'h0, ready1}, 32'(edges[1] >= 32));
    chk("ready2", {31'h0, ready2}, 32'(edges[2] >= 24));
  end

  initial begin
    model_reset();
    idle();
    rd_addr = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    for (int n = 1; n <= 34; n++) begin
      rand_rd();
      idle();
      if (n == 5) begin
        wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h0000_DEAD;
      end
      tick();
      chk($sformatf("ready0_edge%0d", n), {31'h0, ready0}, 32'(n >= 32));
      chk($sformatf("ready2_edge%0d", n), {31'h0, ready2}, 32'(n >= 24));
    end

    idle();
    for (int i = 0; i < 32; i++) begin
      rd_addr[0] = 5'(i);
      #1;
      chk($sformatf("clear_entry%0d", i), rd0[0], 32'h0);
      tick();
    end

    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h1111_1111;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h2222_2222;
    rd_addr[0] = 5'd7;
    #2;
    chk("bypass_a_wins", rd0[0], 32'h1111_1111);
    tick();
    idle();
    #1;
    chk("conflict_stored", rd0[0], 32'h1111_1111);

    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFF_FFFF;
    tick();
    idle();
    rd_addr[0] = 5'd0;
    #1;
    chk("zero_reg_on", rd0[0], 32'h0);
    chk("zero_reg_off", rd1[0], 32'hFFFF_FFFF);
    bs_en = 1'b1; bs_addr = 5'd0;
    tick();
    idle();
    chk("busy0_zero", {31'h0, busy0[0]}, 32'h0);
    chk("busy1_zero", {31'h0, busy1[0]}, 32'h1);

    bs_en = 1'b1; bs_addr = 5'd5;
    tick();
    idle();
    chk("busy_set5", {31'h0, busy0[5]}, 32'h1);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
    tick();
    idle();
    chk("busy_clr5", {31'h0, busy0[5]}, 32'h0);
    bs_en = 1'b1; bs_addr = 5'd9;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    tick();
    idle();
    chk("busy_set_wins9", {31'h0, busy0[9]}, 32'h1);

    wa_en = 1'b1; wa_addr = 5'd30; wa_data = 32'h5;
    tick();
    idle();
    rd_addr[0] = 5'd30;
    #1;
    chk("d24_oob_read", rd2[0], 32'h0);
    chk("d32_addr30", rd0[0], 32'h5);

    repeat (1500) begin
      rand_rd();
      wa_en = 1'($urandom); wa_addr = 5'($urandom); wa_data = $urandom;
      wb_en = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
      bs_en = 1'($urandom); bs_addr = 5'($urandom);
      if (($urandom % 4) == 0) wb_addr = wa_addr;
      if (($urandom % 4) == 0) bs_addr = wb_addr;
      if (($urandom % 3) == 0) rd_addr[1] = wa_addr;
      if (($urandom % 3) == 0) rd_addr[2] = wb_addr;
      tick();
    end

    idle();
    wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h0000_ABCD;
    bs_en = 1'b1; bs_addr = 5'd12;
    tick();
    idle();
    rd_addr[0] = 5'd4;
    #1;
    chk("pre_reset_val", rd0[0], 32'h0000_ABCD);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_ready_drop", {31'h0, ready0}, 32'h0);
    chk("reset_busy_drop", busy0, 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (32) tick();
    rd_addr[0] = 5'd4;
    #1;
    chk("reclear_addr4", rd0[0], 32'h0);
    chk("reclear_busy", busy0, 32'h0);
    chk("reclear_ready", {31'h0, ready0}, 32'h1);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
